// File: rtl/pulse_sequencer.sv
// Pulse descriptor sequencer: buffers descriptors from the core and issues each one
// to the pulse engine when the free-running timebase reaches its start time.
//
// state | meaning
// ARMED | engine idle; the FIFO head may issue once it is due
// HOLD  | engine busy for t_len cycles after an issue; no decision is made
module pulse_sequencer #(
   parameter int DEPTH   = 16,
   parameter int PHASE_W = 32,
   parameter int AMP_W   = 16,
   parameter int TIME_W  = 24,
   parameter int LEN_W   = 16,
   parameter int ENV_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [PHASE_W-1:0]       s_freq,
   input  logic [15:0]              s_phase,
   input  logic [AMP_W-1:0]         s_amp,
   input  logic [TIME_W-1:0]        s_t_start,
   input  logic [LEN_W-1:0]         s_t_len,
   input  logic [ENV_W-1:0]         s_env_addr,
   input  logic                     run,
   input  logic                     time_clr,
   input  logic                     err_clr,
   output logic [TIME_W-1:0]        now,
   output logic                     pulse_ready,
   output logic [PHASE_W-1:0]       freq_trig,
   output logic [15:0]              phase_trig,
   output logic [AMP_W-1:0]         amp_trig,
   output logic [TIME_W-1:0]        t_start_trig,
   output logic [LEN_W-1:0]         t_len_trig,
   output logic [ENV_W-1:0]         env_addr_trig,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     late_err,
   output logic                     len_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ARMED, HOLD} state_t;

   logic [PHASE_W-1:0] mem_freq     [DEPTH];
   logic [15:0]        mem_phase    [DEPTH];
   logic [AMP_W-1:0]   mem_amp      [DEPTH];
   logic [TIME_W-1:0]  mem_t_start  [DEPTH];
   logic [LEN_W-1:0]   mem_t_len    [DEPTH];
   logic [ENV_W-1:0]   mem_env_addr [DEPTH];

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [LEN_W-1:0]   hold_cnt;
   state_t             state;

   logic [TIME_W-1:0]  diff;
   logic               push;
   logic               store;
   logic               late;
   logic               pop;

   assign s_ready    = (count != CNT_W'(DEPTH));
   assign fifo_count = count;

   assign push  = s_valid & s_ready;
   assign store = push & (s_t_len != '0);

   // Signed distance to the head start time; one cycle of lead hides the issue register.
   assign diff  = mem_t_start[rd_ptr] - now;
   assign late  = diff[TIME_W-1] | (diff == '0);
   assign pop   = (state == ARMED) & (count != '0) & run & (late | (diff == TIME_W'(1)));

   always_ff @(posedge clk) begin
      if (store) begin
         mem_freq[wr_ptr]     <= s_freq;
         mem_phase[wr_ptr]    <= s_phase;
         mem_amp[wr_ptr]      <= s_amp;
         mem_t_start[wr_ptr]  <= s_t_start;
         mem_t_len[wr_ptr]    <= s_t_len;
         mem_env_addr[wr_ptr] <= s_env_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         now           <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         pulse_ready   <= 1'b0;
         freq_trig     <= '0;
         phase_trig    <= '0;
         amp_trig      <= '0;
         t_start_trig  <= '0;
         t_len_trig    <= '0;
         env_addr_trig <= '0;
         late_err      <= 1'b0;
         len_err       <= 1'b0;
         hold_cnt      <= '0;
         state         <= ARMED;
      end else begin
         if (time_clr)
            now <= '0;
         else if (run)
            now <= now + TIME_W'(1);

         if (store)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);

         if (store & ~pop)
            count <= count + CNT_W'(1);
         else if (pop & ~store)
            count <= count - CNT_W'(1);

         pulse_ready <= pop;
         if (pop) begin
            freq_trig     <= mem_freq[rd_ptr];
            phase_trig    <= mem_phase[rd_ptr];
            amp_trig      <= mem_amp[rd_ptr];
            t_start_trig  <= mem_t_start[rd_ptr];
            t_len_trig    <= mem_t_len[rd_ptr];
            env_addr_trig <= mem_env_addr[rd_ptr];
         end

         late_err <= (pop & late) | (late_err & ~err_clr);
         len_err  <= (push & (s_t_len == '0)) | (len_err & ~err_clr);

         // HOLD keeps counting regardless of run/time_clr: the engine is still playing.
         case (state)
            ARMED: begin
               if (pop) begin
                  hold_cnt <= mem_t_len[rd_ptr];
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt <= LEN_W'(1)) begin
                  hold_cnt <= '0;
                  state    <= ARMED;
               end else begin
                  hold_cnt <= hold_cnt - LEN_W'(1);
               end
            end
            default: state <= ARMED;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based timing model of the descriptor issue rules.
module tb_pulse_sequencer;

   localparam int DEPTH = 16;
   localparam int TW    = 12;
   localparam int TMOD  = 1 << TW;

   typedef struct {
      logic [31:0]   freq;
      logic [15:0]   phase;
      logic [15:0]   amp;
      logic [TW-1:0] ts;
      logic [15:0]   len;
      logic [15:0]   env;
   } desc_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [31:0]   s_freq = '0;
   logic [15:0]   s_phase = '0;
   logic [15:0]   s_amp = '0;
   logic [TW-1:0] s_t_start = '0;
   logic [15:0]   s_t_len = '0;
   logic [15:0]   s_env_addr = '0;
   logic          run = 1'b0;
   logic          time_clr = 1'b0;
   logic          err_clr = 1'b0;
   logic [TW-1:0] now;
   logic          pulse_ready;
   logic [31:0]   freq_trig;
   logic [15:0]   phase_trig;
   logic [15:0]   amp_trig;
   logic [TW-1:0] t_start_trig;
   logic [15:0]   t_len_trig;
   logic [15:0]   env_addr_trig;
   logic [4:0]    fifo_count;
   logic          late_err;
   logic          len_err;

   int checks = 0;
   int errors = 0;

   pulse_sequencer #(.DEPTH(DEPTH), .TIME_W(TW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_freq(s_freq), .s_phase(s_phase), .s_amp(s_amp), .s_t_start(s_t_start),
      .s_t_len(s_t_len), .s_env_addr(s_env_addr), .run(run), .time_clr(time_clr),
      .err_clr(err_clr), .now(now), .pulse_ready(pulse_ready), .freq_trig(freq_trig),
      .phase_trig(phase_trig), .amp_trig(amp_trig), .t_start_trig(t_start_trig),
      .t_len_trig(t_len_trig), .env_addr_trig(env_addr_trig), .fifo_count(fifo_count),
      .late_err(late_err), .len_err(len_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   desc_t   q[$];
   desc_t   m_trig;
   int      m_now = 0;
   bit      m_pr = 0;
   bit      m_late = 0;
   bit      m_lenerr = 0;
   bit      m_valid = 0;
   longint  cyc = 0;
   longint  free_at = 0;

   function automatic int sdiff(int ts, int n);
      int d;
      d = ((ts - n) % TMOD + TMOD) % TMOD;
      if (d >= TMOD / 2) d -= TMOD;
      return d;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit    issue, late, acc, lenz;
      int    d;
      desc_t nd;
      if (rst) begin
         q.delete();
         m_now = 0; m_pr = 0; m_late = 0; m_lenerr = 0;
         m_trig = '{default: '0};
         free_at = 0;
         m_valid = 1;
      end else if (m_valid) begin
         issue = 0; late = 0;
         // Engine is free once len cycles have passed after the previous strobe.
         if (q.size() > 0 && run && cyc >= free_at) begin
            d = sdiff(int'(q[0].ts), m_now);
            if (d <= 1) begin issue = 1; late = (d <= 0); end
         end
         acc  = s_valid && (q.size() < DEPTH);
         lenz = acc && (s_t_len == 0);
         if (time_clr) m_now = 0;
         else if (run) m_now = (m_now + 1) % TMOD;
         m_pr = issue;
         if (issue) begin
            m_trig  = q.pop_front();
            free_at = cyc + 1 + longint'(m_trig.len);
         end
         if (acc && !lenz) begin
            nd.freq = s_freq; nd.phase = s_phase; nd.amp = s_amp;
            nd.ts = s_t_start; nd.len = s_t_len; nd.env = s_env_addr;
            q.push_back(nd);
         end
         m_late   = late || (m_late && !err_clr);
         m_lenerr = lenz || (m_lenerr && !err_clr);
      end
      cyc++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("now", now, m_now);
         check("s_ready", s_ready, q.size() < DEPTH);
         check("fifo_count", fifo_count, q.size());
         check("pulse_ready", pulse_ready, m_pr);
         check("freq_trig", freq_trig, m_trig.freq);
         check("phase_trig", phase_trig, m_trig.phase);
         check("amp_trig", amp_trig, m_trig.amp);
         check("t_start_trig", t_start_trig, m_trig.ts);
         check("t_len_trig", t_len_trig, m_trig.len);
         check("env_addr_trig", env_addr_trig, m_trig.env);
         check("late_err", late_err, m_late);
         check("len_err", len_err, m_lenerr);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1; s_valid = 0; run = 0; time_clr = 0; err_clr = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic drive_desc(logic [TW-1:0] ts, logic [15:0] len);
      s_valid    = 1;
      s_freq     = $urandom;
      s_phase    = 16'($urandom);
      s_amp      = 16'($urandom);
      s_env_addr = 16'($urandom);
      s_t_start  = ts;
      s_t_len    = len;
   endtask

   task automatic put(logic [TW-1:0] ts, logic [15:0] len);
      @(negedge clk);
      drive_desc(ts, len);
      @(negedge clk);
      s_valid = 0;
   endtask

   task automatic wait_pulse(int limit, output int nv, output bit ok);
      ok = 0; nv = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (pulse_ready) begin
            nv = int'(now); ok = 1;
            return;
         end
      end
   endtask

   task automatic wait_now(int target, int limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (int'(now) == target) begin ok = 1; return; end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int  nv, w, npulse;
      bit  ok;

      // reset values
      do_reset();
      check("rst_now", now, 0);
      check("rst_count", fifo_count, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_pulse_ready", pulse_ready, 0);

      // single on-time pulse
      run = 1;
      put(100, 8);
      wait_pulse(300, nv, ok);
      check("t1_seen", ok, 1);
      check("t1_now", nv, 100);
      check("t1_t_start_trig", t_start_trig, 100);
      check("t1_t_len_trig", t_len_trig, 8);
      check("t1_late", late_err, 0);
      @(negedge clk);
      check("t1_one_cycle", pulse_ready, 0);
      repeat (10) @(negedge clk);

      // busy window pushes the second pulse late
      do_reset();
      run = 1;
      put(50, 20);
      put(55, 4);
      wait_pulse(200, nv, ok);
      check("t2_a_now", nv, 50);
      check("t2_a_late", late_err, 0);
      wait_pulse(200, nv, ok);
      check("t2_b_now", nv, 71);
      check("t2_b_late", late_err, 1);
      repeat (8) @(negedge clk);

      // full FIFO, hold-off, push and pop in the same cycle
      do_reset();
      put(5, 3);
      put(6, 3);
      for (int i = 0; i < 14; i++) put(2000, 3);
      @(negedge clk);
      drive_desc(2000, 3);
      @(negedge clk);
      s_valid = 0;
      check("t3_full_count", fifo_count, 16);
      check("t3_full_ready", s_ready, 0);
      run = 1;
      wait_pulse(50, nv, ok);
      check("t3_p1_now", nv, 5);
      check("t3_p1_count", fifo_count, 15);
      check("t3_p1_ready", s_ready, 1);
      wait_now(8, 10, ok);
      check("t3_reach8", ok, 1);
      drive_desc(2000, 3);
      @(negedge clk);
      s_valid = 0;
      check("t3_p2_strobe", pulse_ready, 1);
      check("t3_p2_count", fifo_count, 15);
      check("t3_p2_late", late_err, 1);

      // timebase wrap
      do_reset();
      run = 1;
      wait_now(12'hFF0, 5000, ok);
      check("t4_reach_ff0", ok, 1);
      put(12'h005, 2);
      wait_pulse(64, nv, ok);
      check("t4_wrap_now", nv, 5);
      check("t4_wrap_late", late_err, 0);
      repeat (4) @(negedge clk);
      @(negedge clk);
      w = int'(now);
      drive_desc(12'hF00, 2);
      @(negedge clk);
      s_valid = 0;
      @(negedge clk);
      check("t4_past_strobe", pulse_ready, 1);
      check("t4_past_now", now, (w + 2) % TMOD);
      check("t4_past_late", late_err, 1);
      repeat (4) @(negedge clk);

      // zero-length descriptor
      do_reset();
      put(12'h100, 0);
      repeat (2) @(negedge clk);
      check("t5_count", fifo_count, 0);
      check("t5_len_err", len_err, 1);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      check("t5_len_clr", len_err, 0);

      // reset during HOLD
      do_reset();
      run = 1;
      put(10, 50);
      put(20, 5);
      put(30, 5);
      wait_pulse(100, nv, ok);
      check("t6_first_now", nv, 10);
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("t6_count", fifo_count, 0);
      check("t6_now", now, 0);
      check("t6_freq_trig", freq_trig, 0);
      check("t6_t_len_trig", t_len_trig, 0);
      npulse = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (pulse_ready) npulse++;
      end
      check("t6_no_pulse", npulse, 0);

      // randomized traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst      = ($urandom % 1000) == 0;
         run      = ($urandom % 10) != 0;
         time_clr = ($urandom % 300) == 0;
         err_clr  = ($urandom % 50) == 0;
         drive_desc(TW'((m_now + TMOD + int'($urandom_range(0, 80)) - 20) % TMOD),
                    (($urandom % 12) == 0) ? 16'd0 : 16'($urandom_range(1, 12)));
         s_valid  = ($urandom % 3) == 0;
      end
      @(negedge clk);
      rst = 0; s_valid = 0; time_clr = 0; err_clr = 0;
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Upstream stage of the pulse engine. Buffers pulse descriptors written by the RISC-V core in a DEPTH-entry FIFO and runs a free-running TIME_W timebase.
- Issues each descriptor to the pulse engine as a one-cycle pulse_ready strobe with the trigger fields, in the cycle its start time is reached.
- Enforces the engine's busy window between consecutive pulses.
- Flags late and illegal descriptors via sticky error bits.

Parameters:
DEPTH, 16, descriptor FIFO entries (power of 2)
PHASE_W, 32, FCW width
AMP_W, 16, amplitude width
TIME_W, 24, timebase / start-time width
LEN_W, 16, pulse length width
ENV_W, 16, envelope address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  descriptor write valid
s_ready  out  1  FIFO can accept (count < DEPTH)
s_freq  in  PHASE_W  FCW
s_phase  in  16  start phase
s_amp  in  AMP_W  amplitude
s_t_start  in  TIME_W  absolute start time
s_t_len  in  LEN_W  length in samples
s_env_addr  in  ENV_W  envelope base address
run  in  1  timebase and issue enable
time_clr  in  1  clear timebase
err_clr  in  1  clear sticky errors
now  out  TIME_W  current timebase value
pulse_ready  out  1  one-cycle issue strobe to engine
freq_trig  out  PHASE_W  issued FCW
phase_trig  out  16  issued phase
amp_trig  out  AMP_W  issued amplitude
t_start_trig  out  TIME_W  issued start time
t_len_trig  out  LEN_W  issued length
env_addr_trig  out  ENV_W  issued envelope address
fifo_count  out  $clog2(DEPTH)+1  occupancy
late_err  out  1  sticky: a pulse issued after its start time
len_err  out  1  sticky: zero-length descriptor dropped

Behaviour:
Reset (rst=1 at posedge):
- now=0, FIFO empty, fifo_count=0, s_ready=1.
- pulse_ready=0; all *_trig outputs =0.
- late_err=0, len_err=0; state ARMED; hold_cnt=0.
- Applies mid-pulse too: queued descriptors are discarded and no further strobe is issued.

Write:
- Handshake completes when s_valid & s_ready.
- s_t_len==0: the descriptor is consumed but not stored, and len_err is set.
- A push and a pop in the same cycle leave the count unchanged.
- s_ready is derived from registered count only. There is no combinational path from pulse_ready to s_ready.

Timebase:
- time_clr has priority: now<=0.
- Otherwise, if run=1, now<=now+1, wrapping modulo 2^TIME_W.
- run=0 freezes now.

Issue FSM (ARMED, HOLD):
- Decision is made in cycle C on the registered FIFO head: diff = (head.t_start - now) mod 2^TIME_W, interpreted as signed.
- ARMED, FIFO non-empty, run=1, diff<=1:
  - Pop the head.
  - In cycle C+1: pulse_ready=1 and all *_trig outputs = head fields.
  - hold_cnt<=head.t_len; go to HOLD.
  - If diff<=0, set late_err.
- On-time rule: on-time issue gives pulse_ready high in the cycle where now==t_start.
- Wrap-around: a start time up to 2^(TIME_W-1)-1 ahead is treated as future; anything else is treated as late.
- HOLD:
  - hold_cnt decrements each cycle; return to ARMED when it reaches 0.
  - Result: the next pulse_ready is no earlier than len+1 cycles after the previous one. This is the engine's capture cycle plus len PLAY cycles.
  - A due descriptor waiting in HOLD issues late when HOLD ends, and sets late_err.
- Output holding:
  - pulse_ready is high for exactly one cycle per issue.
  - The *_trig outputs hold their last issued values until the next issue.
- Latency: a descriptor accepted in cycle W is eligible for decision from W+1, so pulse_ready is at the earliest in W+2.
- time_clr while in HOLD: the hold counter is unaffected.
- run=0 in HOLD: the hold counter still decrements, because the engine keeps playing.

Errors:
- late_err and len_err are sticky.
- err_clr clears them. If set and clear occur in the same cycle, set wins.

Test Plan:
- Write {t_start=100, t_len=8}, run=1 from now=0 -> pulse_ready high for exactly one cycle with now==100; trig fields match the descriptor; late_err=0.
- Write A{t_start=50, len=20} and B{t_start=55, len=4} -> A issues at now=50; B issues at now=71 (50+20+1); late_err=1.
- Fill 16 descriptors with start times far in the future -> s_ready=0 and fifo_count=16. A 17th s_valid is held off. After the first issue, s_ready=1 and fifo_count=15; push and pop in the same cycle keep the count at 15.
- Set now near wrap (time_clr, then run to 0xFFFFF0); write t_start=0x000005 -> issues at now==0x000005 after wrap, not late. Write t_start=0xFFFF00 -> issues immediately with late_err=1.
- Write t_len=0 -> fifo_count stays 0, no pulse_ready, len_err=1. err_clr -> len_err=0.
- Queue 3 descriptors, issue one, assert rst during HOLD -> all outputs at reset values, fifo_count=0, no further pulse_ready.
